// File: rtl/dac_update_sched.sv
// dac_update_sched: round-robin arbiter that scales a granted voltage by -819.2, saturates it and drives one shared DAC.
// Build option DAC_SCHED_OFFSET_BINARY_EN selects an offset-binary DAC_CODE (MSB inverted, reset at midscale).
module dac_update_sched #(
    parameter int N_REQ       = 4,
    parameter int FLOAT_WIDTH = 64,
    parameter int INT_WIDTH   = 16,
    parameter int DAC_WIDTH   = 14,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ENABLE,
    input  logic [N_REQ-1:0]             REQ_VALID,
    input  logic [N_REQ*FLOAT_WIDTH-1:0] REQ_VOLTAGE,
    output logic [N_REQ-1:0]             REQ_READY,
    output logic [DAC_WIDTH-1:0]         DAC_CODE,
    output logic                         DAC_VALID,
    output logic [$clog2(N_REQ)-1:0]     DAC_SEL,
    output logic                         BUSY
);
    localparam int SW   = $clog2(N_REQ);
    localparam int FW   = FLOAT_WIDTH;
    localparam int PW   = 2 * FW;
    localparam int FRAC = FW - INT_WIDTH;
    localparam int HW   = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    // K = -819.2 in Q16.48, realigned to this build's fractional width
    localparam logic signed [127:0] K48 = {{64{1'b1}}, 64'hFCCC_CCCC_CCCC_CCCC};
    localparam logic signed [127:0] KS  = FRAC >= 48 ? K48 <<< (FRAC >= 48 ? FRAC - 48 : 0)
                                                     : K48 >>> (FRAC < 48 ? 48 - FRAC : 0);
    localparam logic signed [FW-1:0] K    = KS[FW-1:0];
    localparam logic signed [PW-1:0] DMAX = PW'(2 ** (DAC_WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] DMIN = ~DMAX;
`ifdef DAC_SCHED_OFFSET_BINARY_EN
    localparam logic [DAC_WIDTH-1:0] FLIP = {1'b1, {(DAC_WIDTH-1){1'b0}}};
`else
    localparam logic [DAC_WIDTH-1:0] FLIP = '0;
`endif

    typedef enum logic [1:0] {IDLE, CONV, OUT, HOLD} state_t;

    state_t                 state;
    logic [SW-1:0]          ptr, grant, idx_r;
    logic [HW-1:0]          cnt;
    logic                   found, fire;
    logic signed [FW-1:0]   sel_v;
    logic signed [PW-1:0]   prod_r, flo;
    logic [DAC_WIDTH-1:0]   sat;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && REQ_VALID[SW'((int'(ptr) + i) % N_REQ)]) begin
                grant = SW'((int'(ptr) + i) % N_REQ);
                found = 1'b1;
            end
        end
        fire      = (state == IDLE) && ENABLE && found;
        REQ_READY = fire ? N_REQ'(1) << grant : '0;
        sel_v     = REQ_VOLTAGE[grant*FW +: FW];
        flo       = prod_r >>> (2 * FRAC);
        sat       = flo > DMAX ? DMAX[DAC_WIDTH-1:0] : flo < DMIN ? DMIN[DAC_WIDTH-1:0] : flo[DAC_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            DAC_CODE  <= FLIP;
            DAC_VALID <= 1'b0;
            DAC_SEL   <= '0;
            BUSY      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            idx_r     <= '0;
            prod_r    <= '0;
        end else begin
            DAC_VALID <= 1'b0;
            case (state)
                IDLE: if (fire) begin
                    prod_r <= sel_v * K;
                    idx_r  <= grant;
                    ptr    <= grant == SW'(N_REQ - 1) ? '0 : grant + 1'b1;
                    state  <= CONV;
                    BUSY   <= 1'b1;
                end
                CONV: begin
                    DAC_CODE  <= sat ^ FLIP;
                    DAC_SEL   <= idx_r;
                    DAC_VALID <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    cnt   <= '0;
                    state <= HOLD_CYCLES > 0 ? HOLD : IDLE;
                    BUSY  <= HOLD_CYCLES > 0;
                end
                default: if (cnt == HOLD_LAST) begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_update_sched.sv
// tb_dac_update_sched: table-driven and sequence checks of the shared DAC scheduler (HOLD=8 and HOLD=0 instances).
// Expected codes follow the DAC_SCHED_OFFSET_BINARY_EN build option automatically.
module tb_dac_update_sched;
`ifdef DAC_SCHED_OFFSET_BINARY_EN
    localparam logic [13:0] FLIP = 14'h2000;
`else
    localparam logic [13:0] FLIP = 14'h0000;
`endif
    logic         clk = 1'b0;
    logic         rst, en;
    logic [3:0]   valid, valid_b, ready, ready_b;
    logic [255:0] volt;
    logic [13:0]  code, code_b;
    logic         dv, dv_b, busy, busy_b;
    logic [1:0]   sel, sel_b;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    dac_update_sched #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
        .CLK(clk), .RST(rst), .ENABLE(en), .REQ_VALID(valid), .REQ_VOLTAGE(volt),
        .REQ_READY(ready), .DAC_CODE(code), .DAC_VALID(dv), .DAC_SEL(sel), .BUSY(busy)
    );

    dac_update_sched #(.N_REQ(4), .HOLD_CYCLES(0)) dut_b (
        .CLK(clk), .RST(rst), .ENABLE(en), .REQ_VALID(valid_b), .REQ_VOLTAGE(volt),
        .REQ_READY(ready_b), .DAC_CODE(code_b), .DAC_VALID(dv_b), .DAC_SEL(sel_b), .BUSY(busy_b)
    );

    typedef struct {
        int          r;
        logic [63:0] v;
        logic [13:0] code;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        valid = '0;
        valid_b = '0;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 50 && busy; k++) tick;
        chk("idle wait", 64'(busy), 0);
    endtask

    task automatic run_one(input int r, input logic [63:0] v, input logic [13:0] exp, input int n);
        wait_idle;
        volt[r*64 +: 64] = v;
        valid = 4'b0001 << r;
        #1;
        chk($sformatf("v%0d ready", n), 64'(ready), 64'(4'b0001 << r));
        tick;
        valid = '0;
        chk($sformatf("v%0d conv no pulse", n), 64'(dv), 0);
        tick;
        chk($sformatf("v%0d pulse", n), 64'(dv), 1);
        chk($sformatf("v%0d code", n), 64'(code), 64'(exp ^ FLIP));
        chk($sformatf("v%0d sel", n), 64'(sel), 64'(r));
        tick;
        chk($sformatf("v%0d pulse end", n), 64'(dv), 0);
        chk($sformatf("v%0d code hold", n), 64'(code), 64'(exp ^ FLIP));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, np, lows, seen;
        int          acc_idx[8], acc_cyc[8], pul_cyc[8], pul_sel[8];
        logic [63:0] busy_hist;
        tbl[0] = '{0, 64'h0001_0000_0000_0000, 14'h3CCC};
        tbl[1] = '{1, 64'hFFFF_0000_0000_0000, 14'h0333};
        tbl[2] = '{2, 64'h0000_0000_0000_0000, 14'h0000};
        tbl[3] = '{3, 64'h000F_0000_0000_0000, 14'h2000};
        tbl[4] = '{0, 64'hFFF1_0000_0000_0000, 14'h1FFF};
        tbl[5] = '{1, 64'h0000_8000_0000_0000, 14'h3E66};
        tbl[6] = '{2, 64'hFFFF_8000_0000_0000, 14'h0199};
        tbl[7] = '{3, 64'h000A_0000_0000_0000, 14'h2000};
        tbl[8] = '{0, 64'hFFF6_0000_0000_0000, 14'h1FFF};
        tbl[9] = '{1, 64'h0000_0000_0000_0001, 14'h3FFF};
        en = 1'b1;
        volt = '0;
        do_reset;
        tick;
        chk("reset code", 64'(code), 64'(FLIP));
        chk("reset valid", 64'(dv), 0);
        chk("reset sel", 64'(sel), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset ready", 64'(ready), 0);
        for (int i = 0; i < 10; i++) run_one(tbl[i].r, tbl[i].v, tbl[i].code, i);

        // all four requesters continuously valid
        do_reset;
        for (int r = 0; r < 4; r++) volt[r*64 +: 64] = 64'(r + 1) << 48;
        valid = 4'hF;
        n = 0;
        busy_hist = '0;
        for (int c = 0; c < 60; c++) begin
            #1;
            busy_hist[c] = busy;
            if (|ready && n < 8) begin
                chk("rr onehot", 64'($countones(ready)), 1);
                for (int b = 0; b < 4; b++) if (ready[b]) acc_idx[n] = b;
                acc_cyc[n] = c;
                n++;
            end
            tick;
        end
        valid = '0;
        chk("rr accept count", 64'(n >= 5), 1);
        for (int k = 0; k < 5 && k < n; k++) chk($sformatf("rr order %0d", k), 64'(acc_idx[k]), 64'(k % 4));
        for (int k = 1; k < 5 && k < n; k++) chk($sformatf("rr spacing %0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 11);
        if (n >= 5) begin
            lows = 0;
            for (int c = acc_cyc[0]; c < acc_cyc[4]; c++) lows += busy_hist[c] ? 0 : 1;
            chk("busy low cycles", 64'(lows), 4);
        end

        // zero hold: back-to-back conversions
        valid_b = 4'hF;
        np = 0;
        for (int c = 0; c < 16; c++) begin
            if (dv_b && np < 8) begin
                pul_cyc[np] = c;
                pul_sel[np] = sel_b;
                np++;
            end
            tick;
        end
        valid_b = '0;
        chk("hold0 pulse count", 64'(np >= 4), 1);
        for (int k = 1; k < 4 && k < np; k++) chk($sformatf("hold0 spacing %0d", k), 64'(pul_cyc[k] - pul_cyc[k-1]), 3);
        for (int k = 0; k < 4 && k < np; k++) chk($sformatf("hold0 sel %0d", k), 64'(pul_sel[k]), 64'(k));

        // enable dropped right after an accept
        do_reset;
        volt[128 +: 64] = 64'h0001_0000_0000_0000;
        volt[64 +: 64]  = 64'hFFFF_0000_0000_0000;
        valid = 4'b0100;
        #1;
        chk("en ready", 64'(ready), 64'(4'b0100));
        tick;
        en = 1'b0;
        valid = 4'b0010;
        #1;
        chk("en conv ready", 64'(ready), 0);
        tick;
        chk("en pulse", 64'(dv), 1);
        chk("en sel", 64'(sel), 2);
        chk("en code", 64'(code), 64'(14'h3CCC ^ FLIP));
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (ready != 0) seen = 1;
        end
        chk("disabled no ready", 64'(seen), 0);
        chk("disabled idle", 64'(busy), 0);
        en = 1'b1;
        #1;
        chk("reenable rr", 64'(ready), 64'(4'b0010));
        tick;
        rst = 1'b1;
        valid = '0;
        tick;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (dv) seen = 1;
            tick;
        end
        chk("rst drop pulse", 64'(seen), 0);
        chk("rst code", 64'(code), 64'(FLIP));
        chk("rst sel", 64'(sel), 0);
        chk("rst busy", 64'(busy), 0);
        valid = 4'hF;
        #1;
        chk("rst ptr", 64'(ready), 64'(4'b0001));
        valid = '0;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
